frame_writer_background: RTL

Write-side counterpart of the background frame RAM reader. It accepts a raster-order stream of 24-bit RGB pixels over a valid/ready handshake. Each pixel is reverse-mapped through the 11-entry wood-background palette to a 4-bit index. The index is written into the 4-bit x 307200 background frame memory through a synchronous write port. It sits between the pixel source (loader/compositor) and the frame RAM write port, and fills exactly one 640x480 frame per start.

---
 rtl/frame_writer_background.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/frame_writer_background.sv
// Streams raster-order RGB pixels into the background frame RAM, mapping each
// colour back to its 4-bit wood-palette index through a two-stage pipeline.
module frame_writer_background #(
   parameter int H_PIXELS = 640,
   parameter int V_PIXELS = 480,
   parameter int ADDR_W   = 19,
   parameter int IDX_W    = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              abort,
   input  logic [23:0]       pixel_in,
   input  logic              pixel_valid,
   output logic              pixel_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [IDX_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] miss_count
);

   localparam int NUM_COLORS = 11;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_PIXELS - 1);
   localparam logic [ADDR_W-1:0] MISS_MAX  = '1;
   localparam logic [23:0] PALETTE [NUM_COLORS] = '{
      24'hFF0000, 24'h3B2012, 24'h4B2A15, 24'h5B3719, 24'h774425, 24'hA05B2A,
      24'hAB672D, 24'hBA6F32, 24'h3B2011, 24'h462612, 24'h754324
   };

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                s1_valid_q, s1_valid_d;
   logic [23:0]         s1_pixel_q, s1_pixel_d;
   logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [IDX_W-1:0]    wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]   miss_q, miss_d;
   logic                accept;
   logic                hit;
   logic [IDX_W-1:0]    match_idx;
   logic                aborting;

   assign accept   = (state_q == FILL) && pixel_valid;
   assign aborting = abort && ((state_q == FILL) || (state_q == DRAIN));

   // Scan from the top so the lowest matching index is the one that sticks.
   always_comb begin
      hit       = 1'b0;
      match_idx = '0;
      for (int i = NUM_COLORS - 1; i >= 0; i--) begin
         if (s1_pixel_q == PALETTE[i]) begin
            hit       = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      // NOTE: every signal gets a default up front so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      s1_valid_d = 1'b0;
      s1_pixel_d = s1_pixel_q;
      s1_addr_d  = s1_addr_q;
      wr_en_d    = s1_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      miss_d     = miss_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_pixel_d = pixel_in;
         s1_addr_d  = cnt_q;
         cnt_d      = cnt_q + ADDR_W'(1);
      end

      if (s1_valid_q) begin
         wr_addr_d = s1_addr_q;
         wr_data_d = hit ? match_idx : '0;
         if (!hit && (miss_q != MISS_MAX)) miss_d = miss_q + ADDR_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               cnt_d   = '0;
               miss_d  = '0;
            end
         end
         FILL:    if (accept && (cnt_q == LAST_ADDR)) state_d = DRAIN;
         DRAIN:   if (!s1_valid_q && !wr_en_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Cancelling drops in-flight beats without writing or counting them.
      if (aborting) begin
         state_d    = IDLE;
         s1_valid_d = 1'b0;
         wr_en_d    = 1'b0;
         wr_addr_d  = wr_addr_q;
         wr_data_d  = wr_data_q;
         miss_d     = miss_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_pixel_q <= '0;
         s1_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         miss_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_pixel_q <= s1_pixel_d;
         s1_addr_q  <= s1_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         miss_q     <= miss_d;
      end
   end

   assign pixel_ready = (state_q == FILL);
   assign busy        = (state_q == FILL) || (state_q == DRAIN);
   assign done        = (state_q == DONE);
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign miss_count  = miss_q;

endmodule
